// File: rtl/sc_mon_pkg.sv
// Shared types and helpers for the N-copy self-composition timing monitor.
// The range helper works on a fixed 8 x 32-bit layout so any COPIES/CNT_W fits.
package sc_mon_pkg;

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  localparam int MAX_COPIES = 8;
  localparam int LAT_W      = 32;

  typedef struct packed {
    logic [LAT_W-1:0] lo;
    logic [LAT_W-1:0] hi;
  } lat_range_t;

  // Min/max over the latencies whose mask bit is set; both 0 when the mask is empty.
  function automatic lat_range_t lat_range(input logic [MAX_COPIES*LAT_W-1:0] lats,
                                           input logic [MAX_COPIES-1:0]       mask);
    lat_range_t r;
    logic       any;
    r.lo = '0;
    r.hi = '0;
    any  = 1'b0;
    for (int i = 0; i < MAX_COPIES; i++) begin
      if (mask[i]) begin
        if (!any || (lats[i*LAT_W +: LAT_W] < r.lo)) r.lo = lats[i*LAT_W +: LAT_W];
        if (!any || (lats[i*LAT_W +: LAT_W] > r.hi)) r.hi = lats[i*LAT_W +: LAT_W];
        any = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sc_timing_monitor_if.sv
// Bundle between the composed crypto copies (master side) and the timing monitor (slave side).
// Handshake: start is a one-cycle pulse honoured only when idle/done; finish is a level per copy.
interface sc_timing_monitor_if #(
  parameter int COPIES = 2,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
);
  logic                     start;
  logic [COPIES-1:0]        finish;
  logic [COPIES-1:0]        admissible;
  logic [COPIES*DATA_W-1:0] data;
  logic                     busy;
  logic                     done;
  logic                     leak;
  logic                     data_mismatch;
  logic                     timeout;
  logic                     invalid;
  logic [CNT_W-1:0]         lat_min;
  logic [CNT_W-1:0]         lat_spread;

  modport master (
    output start, finish, admissible, data,
    input  busy, done, leak, data_mismatch, timeout, invalid, lat_min, lat_spread
  );

  modport slave (
    input  start, finish, admissible, data,
    output busy, done, leak, data_mismatch, timeout, invalid, lat_min, lat_spread
  );
endinterface

// File: rtl/sc_lat_channel.sv
// One copy's latency channel: finish edge detect plus latency/data capture and its done bit.
module sc_lat_channel #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic              finish,
  input  logic [DATA_W-1:0] data,
  input  logic [CNT_W-1:0]  cnt,
  output logic              hit,
  output logic              done_bit,
  output logic [CNT_W-1:0]  lat,
  output logic [DATA_W-1:0] cap
);

  logic finish_d;

  // Only the first rising edge of a run is recorded.
  assign hit = en & finish & ~finish_d & ~done_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      finish_d <= 1'b1;
      done_bit <= 1'b0;
      lat      <= '0;
      cap      <= '0;
    end else begin
      finish_d <= finish;
      if (clear) begin
        done_bit <= 1'b0;
        lat      <= '0;
        cap      <= '0;
      end else if (hit) begin
        done_bit <= 1'b1;
        lat      <= cnt;
        cap      <= data;
      end
    end
  end

endmodule

// File: rtl/sc_timing_monitor.sv
// Self-composition timing monitor: times COPIES instances from a shared start and
// publishes leak / data-mismatch / timeout / invalid verdicts once per run.
module sc_timing_monitor
  import sc_mon_pkg::*;
#(
  parameter int COPIES     = 2,
  parameter int DATA_W     = 16,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 4096,
  parameter int TOL        = 0
) (
  input  logic                clk,
  input  logic                rst,
  sc_timing_monitor_if.slave  bus,
  output state_t              state_dbg
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_inc;
  logic [COPIES-1:0]        mask, hit;
  logic [COPIES*CNT_W-1:0]  lat_all;
  logic [COPIES*DATA_W-1:0] cap_all;
  logic                     run_clear, run_en, all_done, set_to;
  logic                     inv_q, to_q;
  logic                     done_r, leak_r, dm_r, to_r, inv_r;
  logic [CNT_W-1:0]         lat_min_r, lat_spread_r;

  logic [MAX_COPIES*LAT_W-1:0] lat_ext;
  logic [MAX_COPIES-1:0]       mask_ext;
  lat_range_t                  rng;
  logic [LAT_W-1:0]            spread_full;
  logic                        diff, leak_v, dm_v;

  assign run_clear = ((state_q == IDLE) || (state_q == DONE)) && bus.start;
  assign run_en    = (state_q == RUN);
  // cnt_inc is the latency value this RUN cycle represents; saturates at MAX_CYCLES.
  assign cnt_inc   = (cnt_q == MAX_C) ? cnt_q : cnt_q + 1'b1;
  assign all_done  = &(mask | hit);

  for (genvar g = 0; g < COPIES; g++) begin : g_ch
    sc_lat_channel #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .clear    (run_clear),
      .en       (run_en),
      .finish   (bus.finish[g]),
      .data     (bus.data[g*DATA_W +: DATA_W]),
      .cnt      (cnt_inc),
      .hit      (hit[g]),
      .done_bit (mask[g]),
      .lat      (lat_all[g*CNT_W +: CNT_W]),
      .cap      (cap_all[g*DATA_W +: DATA_W])
    );
  end

  always_comb begin
    state_d = state_q;
    set_to  = 1'b0;
    case (state_q)
      IDLE, DONE: if (bus.start) state_d = RUN;
      RUN: begin
        if (all_done) begin
          state_d = CHECK;
        end else if (cnt_inc == MAX_C) begin
          state_d = CHECK;
          set_to  = 1'b1;
        end
      end
      CHECK:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lat_ext  = '0;
    mask_ext = '0;
    for (int i = 0; i < COPIES; i++) begin
      lat_ext[i*LAT_W +: LAT_W] = LAT_W'(lat_all[i*CNT_W +: CNT_W]);
      mask_ext[i]               = mask[i];
    end
    rng         = lat_range(lat_ext, mask_ext);
    spread_full = rng.hi - rng.lo;
    diff        = 1'b0;
    for (int i = 1; i < COPIES; i++) begin
      if (cap_all[i*DATA_W +: DATA_W] != cap_all[0 +: DATA_W]) diff = 1'b1;
    end
    // An inadmissible run carries no information, so it never reports a leak or mismatch.
    leak_v = ~inv_q & ((spread_full > LAT_W'(TOL)) | (to_q & |mask));
    dm_v   = ~inv_q & ~to_q & diff;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      inv_q        <= 1'b0;
      to_q         <= 1'b0;
      done_r       <= 1'b0;
      leak_r       <= 1'b0;
      dm_r         <= 1'b0;
      to_r         <= 1'b0;
      inv_r        <= 1'b0;
      lat_min_r    <= '0;
      lat_spread_r <= '0;
    end else begin
      state_q <= state_d;
      done_r  <= 1'b0;
      if (run_clear) begin
        cnt_q        <= '0;
        inv_q        <= 1'b0;
        to_q         <= 1'b0;
        leak_r       <= 1'b0;
        dm_r         <= 1'b0;
        to_r         <= 1'b0;
        inv_r        <= 1'b0;
        lat_min_r    <= '0;
        lat_spread_r <= '0;
      end
      if (run_en) begin
        cnt_q <= cnt_inc;
        if (~&bus.admissible) inv_q <= 1'b1;
        if (set_to) to_q <= 1'b1;
      end
      if (state_q == CHECK) begin
        done_r       <= 1'b1;
        leak_r       <= leak_v;
        dm_r         <= dm_v;
        to_r         <= to_q;
        inv_r        <= inv_q;
        lat_min_r    <= CNT_W'(rng.lo);
        lat_spread_r <= CNT_W'(spread_full);
      end
    end
  end

  assign bus.busy          = (state_q == RUN) || (state_q == CHECK);
  assign bus.done          = done_r;
  assign bus.leak          = leak_r;
  assign bus.data_mismatch = dm_r;
  assign bus.timeout       = to_r;
  assign bus.invalid       = inv_r;
  assign bus.lat_min       = lat_min_r;
  assign bus.lat_spread    = lat_spread_r;
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_sc_timing_monitor.sv
// Drives three monitor configurations from one set of directed run scenarios and checks
// every cycle against a run-level model plus hand-computed literals.
module tb_sc_timing_monitor;
  import sc_mon_pkg::*;

  localparam int MAXC = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus lanes ----------------
  logic        start_s = 1'b0;
  logic [3:0]  fin_s   = 4'h0;
  logic [3:0]  adm_s   = 4'hF;
  logic [15:0] dat_s [4];

  sc_timing_monitor_if #(.COPIES(2), .DATA_W(16), .CNT_W(16)) bus0 ();
  sc_timing_monitor_if #(.COPIES(2), .DATA_W(16), .CNT_W(16)) bus1 ();
  sc_timing_monitor_if #(.COPIES(4), .DATA_W(16), .CNT_W(16)) bus2 ();

  assign bus0.start      = start_s;
  assign bus0.finish     = fin_s[1:0];
  assign bus0.admissible = adm_s[1:0];
  assign bus0.data       = {dat_s[1], dat_s[0]};
  assign bus1.start      = start_s;
  assign bus1.finish     = fin_s[1:0];
  assign bus1.admissible = adm_s[1:0];
  assign bus1.data       = {dat_s[1], dat_s[0]};
  assign bus2.start      = start_s;
  assign bus2.finish     = fin_s;
  assign bus2.admissible = adm_s;
  assign bus2.data       = {dat_s[3], dat_s[2], dat_s[1], dat_s[0]};

  state_t st0, st1, st2;

  sc_timing_monitor #(.COPIES(2), .DATA_W(16), .CNT_W(16), .MAX_CYCLES(MAXC), .TOL(0)) u0 (
    .clk(clk), .rst(rst), .bus(bus0), .state_dbg(st0));
  sc_timing_monitor #(.COPIES(2), .DATA_W(16), .CNT_W(16), .MAX_CYCLES(MAXC), .TOL(4)) u1 (
    .clk(clk), .rst(rst), .bus(bus1), .state_dbg(st1));
  sc_timing_monitor #(.COPIES(4), .DATA_W(16), .CNT_W(16), .MAX_CYCLES(MAXC), .TOL(0)) u2 (
    .clk(clk), .rst(rst), .bus(bus2), .state_dbg(st2));

  // {busy, done, leak, data_mismatch, timeout, invalid, lat_min, lat_spread}
  logic [37:0] act [3];
  assign act[0] = {bus0.busy, bus0.done, bus0.leak, bus0.data_mismatch, bus0.timeout,
                   bus0.invalid, bus0.lat_min, bus0.lat_spread};
  assign act[1] = {bus1.busy, bus1.done, bus1.leak, bus1.data_mismatch, bus1.timeout,
                   bus1.invalid, bus1.lat_min, bus1.lat_spread};
  assign act[2] = {bus2.busy, bus2.done, bus2.leak, bus2.data_mismatch, bus2.timeout,
                   bus2.invalid, bus2.lat_min, bus2.lat_spread};

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- scenario + run-level model ----------------
  int  case_f [4];
  int  case_adm_lane = 0;
  int  case_adm_off  = 0;
  bit  case_hold     = 1'b0;

  int  ncp_of [3] = '{2, 2, 4};
  int  tol_of [3] = '{0, 4, 0};

  bit          ex_valid [3] = '{1'b0, 1'b0, 1'b0};
  int          ex_s [3];
  int          ex_e [3];
  logic [37:0] ex_verdict [3];

  // Latency of copy i is its finish rise offset from start; a run ends at the last
  // finish, or at MAXC if some copy never finishes in time.
  task automatic model_start(input int u);
    int lo, hi, eoff;
    bit all_fin, any, dm, inv, to, leak, dmv;
    lo = 0; hi = 0; all_fin = 1'b1; any = 1'b0; dm = 1'b0;
    for (int i = 0; i < ncp_of[u]; i++) begin
      if (case_f[i] >= 1 && case_f[i] <= MAXC) begin
        if (!any || case_f[i] < lo) lo = case_f[i];
        if (!any || case_f[i] > hi) hi = case_f[i];
        any = 1'b1;
      end else begin
        all_fin = 1'b0;
      end
      if (dat_s[i] != dat_s[0]) dm = 1'b1;
    end
    eoff = all_fin ? hi : MAXC;
    to   = !all_fin;
    inv  = (case_adm_lane < ncp_of[u]) && (case_adm_off >= 1) && (case_adm_off <= eoff);
    leak = !inv && (((hi - lo) > tol_of[u]) || (to && any));
    dmv  = !inv && !to && dm;
    ex_s[u]       = cyc;
    ex_e[u]       = cyc + eoff;
    ex_verdict[u] = {1'b0, 1'b0, leak, dmv, to, inv, 16'(lo), 16'(hi - lo)};
    ex_valid[u]   = 1'b1;
  endtask

  function automatic logic [37:0] exp_vec(input int u, input int k);
    logic [37:0] v;
    if (!ex_valid[u]) return 38'd0;
    if (k <= ex_e[u]) return {1'b1, 37'd0};
    v = ex_verdict[u];
    if (k == ex_e[u] + 1) v[36] = 1'b1;
    return v;
  endfunction

  // ---------------- scoreboard: every-cycle compare ----------------
  always @(negedge clk) begin
    if (cyc >= 2) begin
      for (int u = 0; u < 3; u++) begin
        logic [37:0] e;
        e = exp_vec(u, cyc);
        n_cmp++;
        if (act[u] !== e) begin
          n_bad++;
          $display("FAIL cycle_u%0d at cycle %0d: got %h want %h", u, cyc, act[u], e);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_case(input int f0, input int f1, input int f2, input int f3,
                          input logic [15:0] d2, input int adm_lane, input int adm_off,
                          input bit hold);
    case_f[0] = f0; case_f[1] = f1; case_f[2] = f2; case_f[3] = f3;
    for (int i = 0; i < 4; i++) dat_s[i] = 16'h00A4;
    dat_s[2]      = d2;
    case_adm_lane = adm_lane;
    case_adm_off  = adm_off;
    case_hold     = hold;
  endtask

  task automatic run_case(input int reset_at);
    if (case_hold) begin
      fin_s = 4'hF;
      repeat (2) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1 start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    for (int u = 0; u < 3; u++) model_start(u);
    for (int off = 1; off <= MAXC + 4; off++) begin
      adm_s = 4'hF;
      if (off == case_adm_off) adm_s[case_adm_lane] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (case_hold && off == 2) fin_s[i] = 1'b0;
        if (off == case_f[i])      fin_s[i] = 1'b1;
      end
      @(posedge clk); #1;
      if (reset_at != 0 && off == reset_at) break;
    end
    adm_s = 4'hF;
    if (reset_at != 0) begin
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      for (int u = 0; u < 3; u++) ex_valid[u] = 1'b0;
    end
  endtask

  task automatic settle();
    fin_s = 4'h0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    for (int i = 0; i < 4; i++) dat_s[i] = 16'h00A4;
    for (int i = 0; i < 4; i++) case_f[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_busy", int'(bus0.busy), 0);
    check("reset_state", int'(st0), int'(IDLE));
    repeat (2) begin @(posedge clk); #1; end

    // equal latencies
    set_case(37, 37, 37, 37, 16'h00A4, 0, 0, 1'b0); run_case(0);
    check("eq_lat_min", int'(bus0.lat_min), 37);
    check("eq_spread", int'(bus0.lat_spread), 0);
    check("eq_leak", int'(bus0.leak), 0);
    settle();

    // spread of 4: leak at TOL=0, tolerated at TOL=4
    set_case(37, 41, 37, 37, 16'h00A4, 0, 0, 1'b0); run_case(0);
    check("sp4_lat_min", int'(bus0.lat_min), 37);
    check("sp4_spread", int'(bus0.lat_spread), 4);
    check("sp4_leak_tol0", int'(bus0.leak), 1);
    check("sp4_leak_tol4", int'(bus1.leak), 0);
    settle();

    // four copies, one late and with different data
    set_case(10, 10, 12, 10, 16'h00A5, 0, 0, 1'b0); run_case(0);
    check("c4_spread", int'(bus2.lat_spread), 2);
    check("c4_leak", int'(bus2.leak), 1);
    check("c4_mismatch", int'(bus2.data_mismatch), 1);
    settle();

    // copy 1 never finishes
    set_case(20, 0, 20, 20, 16'h00A4, 0, 0, 1'b0); run_case(0);
    check("to1_timeout", int'(bus0.timeout), 1);
    check("to1_leak", int'(bus0.leak), 1);
    check("to1_lat_min", int'(bus0.lat_min), 20);
    check("to1_spread", int'(bus0.lat_spread), 0);
    settle();

    // nobody finishes
    set_case(0, 0, 0, 0, 16'h00A4, 0, 0, 1'b0); run_case(0);
    check("to0_timeout", int'(bus0.timeout), 1);
    check("to0_leak", int'(bus0.leak), 0);
    settle();

    // admissibility drop mid-run
    set_case(5, 9, 5, 5, 16'h00A4, 1, 4, 1'b0); run_case(0);
    check("inv_invalid", int'(bus0.invalid), 1);
    check("inv_leak", int'(bus0.leak), 0);
    check("inv_mismatch", int'(bus0.data_mismatch), 0);
    check("inv_spread", int'(bus0.lat_spread), 4);
    settle();

    // reset at cnt=15 aborts the run
    set_case(30, 30, 30, 30, 16'h00A4, 0, 0, 1'b0); run_case(15);
    check("rst_state", int'(st0), int'(IDLE));
    check("rst_busy", int'(bus0.busy), 0);
    check("rst_done", int'(bus0.done), 0);
    repeat (3) begin @(posedge clk); #1; end

    // finish held high across start must re-rise before it counts
    set_case(6, 6, 6, 6, 16'h00A4, 0, 0, 1'b1); run_case(0);
    check("hold_lat_min", int'(bus0.lat_min), 6);
    check("hold_timeout", int'(bus0.timeout), 0);
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the scenarios completed");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sc_timing_monitor.md
Name: sc_timing_monitor

Overview:
- Parametrised N-copy self-composition checker for timing side-channel analysis.
- Measures start-to-finish latency of COPIES identical crypto instances that share `start` and low-security inputs but receive different secrets (e.g. p/q per copy).
- Raises `leak` when latencies diverge beyond TOL, and `data_mismatch` when low-security outputs differ.
- Discards runs in which any copy's admissibility input (prime-check assumption) drops.

Parameters:
- COPIES, 2: number of composed instances (2..8).
- DATA_W, 16: width of each copy's output word.
- CNT_W, 16: latency counter width.
- MAX_CYCLES, 4096: run timeout in cycles; must be < 2^CNT_W.
- TOL, 0: maximum allowed latency spread (max-min) without flagging a leak.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  run start pulse, shared by all copies.
- finish  in  COPIES  per-copy finish level from each instance.
- admissible  in  COPIES  per-copy "secret is valid" (AssumePrime AND IsPrime).
- data  in  COPIES*DATA_W  per-copy output word; copy i occupies bits [i*DATA_W +: DATA_W].
- busy  out  1  high in RUN or CHECK.
- done  out  1  one-cycle pulse when a verdict is published.
- leak  out  1  sticky verdict: latency spread exceeded TOL, or copies disagreed on timeout.
- data_mismatch  out  1  sticky verdict: some copy's captured data differs from copy 0.
- timeout  out  1  sticky verdict: MAX_CYCLES reached before all copies finished.
- invalid  out  1  sticky verdict: admissible dropped during the run; leak and data_mismatch are forced to 0.
- lat_min  out  CNT_W  smallest latched latency.
- lat_spread  out  CNT_W  max minus min latched latency.

Behaviour:
- One clock; reset is synchronous and active-high.
- While rst is high at an edge:
  - state goes to IDLE;
  - all outputs become 0, as do cnt, lat[], the done mask, the data captures and the invalid flag;
  - finish_d (previous finish) is set to all ones, so a finish already high out of reset is not seen as an edge.
- finish_d updates every cycle in all states.
- A finish edge for copy i is finish[i] & ~finish_d[i].
- FSM states:
  - IDLE: when start=1, go to RUN. Clear verdicts, lat[], the done mask, invalid and cnt (cnt cleared to 0).
  - RUN: cnt increments by 1 each cycle, so the first RUN cycle sees cnt=1.
    - On a finish edge for copy i with done_mask[i]=0: lat[i]<=cnt, capture data_i, set done_mask[i].
    - A finish edge on the same cycle start is accepted (IDLE) is ignored.
    - Any cycle with ~&admissible sets invalid (sticky for the run).
    - When done_mask becomes all ones (including via this cycle's edges), go to CHECK.
    - Else, if cnt==MAX_CYCLES, go to CHECK with timeout=1.
    - start is ignored in RUN.
  - CHECK (1 cycle): compute the verdict, then go to DONE with done=1 for exactly this transition cycle's output.
    - lat_min and lat_spread are taken over copies with done_mask set; both are 0 if none are set.
    - leak = ~invalid & ((lat_spread > TOL) | (timeout & |done_mask)).
    - data_mismatch = ~invalid & ~timeout & (some data_i != data_0).
  - DONE: hold verdict outputs. start=1 behaves as in IDLE: verdicts clear and RUN is entered.
- Latency is measured in cycles after start: a finish rising in the cycle right after start yields lat=1.
- A copy whose finish stays high from a previous run records only after finish drops and rises again.
- Simultaneous finish edges on several copies in one cycle all latch the same cnt.
- cnt saturates at MAX_CYCLES and never wraps.
- Reset mid-run aborts the run with no done pulse.

Decomposition:
- Package sc_mon_pkg holds:
  - state enum {IDLE, RUN, CHECK, DONE};
  - a function computing min/max over a masked latency array.
- One natural sub-module: sc_lat_channel, instantiated COPIES times via generate. It holds:
  - finish edge detect;
  - the lat and data capture registers;
  - the done_mask bit.
- Spread, compare and FSM logic stay in the top.

Test Plan:
- COPIES=2, TOL=0: start at t0, both finish rise at t0+37 -> done one cycle after entering CHECK; lat_min=37, lat_spread=0, leak=0, data_mismatch=0.
- COPIES=2, TOL=0: copy0 finishes at +37, copy1 at +41, equal data -> lat_min=37, lat_spread=4, leak=1. Repeat with TOL=4 -> leak=0.
- COPIES=4: copies finish at +10,+10,+12,+10 and copy2 data=0x00A5 vs 0x00A4 elsewhere -> lat_spread=2, leak=1, data_mismatch=1.
- MAX_CYCLES=64: copy0 finishes at +20, copy1 never -> timeout=1, leak=1, lat_min=20, lat_spread=0. With neither finishing -> timeout=1, leak=0.
- admissible[1] low for one cycle mid-run, finishes at +5 and +9 -> invalid=1, leak=0, data_mismatch=0, lat_spread=4.
- rst asserted at RUN cnt=15 -> all outputs 0, state IDLE, no done. finish held high across the next start -> no latch until it re-rises.
